// File: rtl/alu_arbiter_pkg.sv
// Shared op-code encodings and width defaults for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned OPW_DEF  = 5;
  localparam int unsigned OP_COUNT = 10;

  typedef enum logic [OPW_DEF-1:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_AND = 5'd2,
    OP_OR  = 5'd3,
    OP_XOR = 5'd4,
    OP_NOR = 5'd5,
    OP_SLT = 5'd6,
    OP_SLL = 5'd7,
    OP_SRL = 5'd8,
    OP_SRA = 5'd9
  } alu_op_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: ten ops on DW-bit operands, shifts move B by the unsigned value of A.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned OPW = OPW_DEF
) (
  input  logic [OPW-1:0] op_i,
  input  logic [DW-1:0]  a_i,
  input  logic [DW-1:0]  b_i,
  output logic [DW-1:0]  result_o,
  output logic           zero_o,
  output logic           err_o
);

  localparam int unsigned SHW = $clog2(DW);
  localparam logic [DW-1:0] DW_V = DW'(DW);

  logic           shift_big;
  logic [SHW-1:0] shamt;

  // Any A of DW or more fully shifts out B; only then is the truncated amount wrong.
  assign shift_big = (a_i >= DW_V);
  assign shamt     = a_i[SHW-1:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      OPW'(OP_ADD): result_o = a_i + b_i;
      OPW'(OP_SUB): result_o = a_i - b_i;
      OPW'(OP_AND): result_o = a_i & b_i;
      OPW'(OP_OR):  result_o = a_i | b_i;
      OPW'(OP_XOR): result_o = a_i ^ b_i;
      OPW'(OP_NOR): result_o = ~(a_i | b_i);
      OPW'(OP_SLT): result_o = {{(DW-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OPW'(OP_SLL): result_o = shift_big ? '0 : (b_i << shamt);
      OPW'(OP_SRL): result_o = shift_big ? '0 : (b_i >> shamt);
      OPW'(OP_SRA): result_o = shift_big ? {DW{b_i[DW-1]}} : DW'($signed(b_i) >>> shamt);
      default:      result_o = '0;
    endcase
  end

  assign err_o  = (op_i >= OPW'(OP_COUNT));
  assign zero_o = (op_i == OPW'(OP_SUB)) && (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter feeding a shared ALU with a registered one-cycle response.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0 (default: round-robin).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           flush,
  input  logic           req0_valid,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic           req1_ready,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [DW-1:0]  rsp_result,
  output logic           rsp_zero,
  output logic           rsp_err
);

  logic           grant0, grant1, xfer;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a, alu_b, alu_res;
  logic           alu_zero, alu_err;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant0 = !stall && req0_valid;
  assign grant1 = !stall && req1_valid && !req0_valid;
`else
  logic ptr_q;  // index of the most recently granted requester

  assign grant0 = !stall && req0_valid && (!req1_valid || ptr_q);
  assign grant1 = !stall && req1_valid && (!req0_valid || !ptr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr_q <= 1'b1;
    else if (xfer) ptr_q <= grant1;
  end
`endif

  assign xfer       = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign alu_op = grant1 ? req1_op : req0_op;
  assign alu_a  = grant1 ? req1_a  : req0_a;
  assign alu_b  = grant1 ? req1_b  : req0_b;

  alu_arbiter_alu #(.DW(DW), .OPW(OPW)) u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_res),
    .zero_o   (alu_zero),
    .err_o    (alu_err)
  );

  logic          rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic [DW-1:0] res_q, res_d;
  logic          zero_q, zero_d, err_q, err_d;

  // A flush discards a transfer accepted on the same edge, so its data is not captured either.
  always_comb begin
    rsp0_d = rsp0_q;
    rsp1_d = rsp1_q;
    res_d  = res_q;
    zero_d = zero_q;
    err_d  = err_q;
    if (!stall) begin
      rsp0_d = grant0;
      rsp1_d = grant1;
      if (xfer && !flush) begin
        res_d  = alu_res;
        zero_d = alu_zero;
        err_d  = alu_err;
      end
    end
    if (flush) begin
      rsp0_d = 1'b0;
      rsp1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rsp0_q <= rsp0_d;
      rsp1_q <= rsp1_d;
      res_q  <= res_d;
      zero_q <= zero_d;
      err_q  <= err_d;
    end
  end

  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;

endmodule
